// File: rtl/spc_reg_write_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// spc_reg_write_arbiter: shares the special-register write port
// between branch redirect, PC increment and user writes.  Rev 1.0
// ------------------------------------------------------------------
module spc_reg_write_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3,
  parameter bit PROT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_req,
  input  logic [31:0] br_target,
  output logic        br_ack,
  input  logic        inc_req,
  input  logic [31:0] inc_pc,
  output logic        inc_ack,
  input  logic        usr_req,
  input  logic [2:0]  usr_addr,
  input  logic [31:0] usr_data,
  output logic        usr_ack,
  input  logic        err_clr,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        flush,
  output logic        prot_err
);

  localparam logic [2:0]        ADDR_ZR    = 3'd0;
  localparam logic [2:0]        ADDR_PC    = 3'd6;
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic              br_ack_q, br_ack_d;
  logic              inc_ack_q, inc_ack_d;
  logic              usr_ack_q, usr_ack_d;
  logic              wr_en_q, wr_en_d;
  logic [2:0]        wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              flush_q, flush_d;
  logic              prot_err_q, prot_err_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic elig_br, elig_inc, elig_usr, usr_aged;
  logic grant_br, grant_inc, grant_usr, usr_blocked;

  always_comb begin
    elig_br   = br_req  & ~br_ack_q;
    elig_inc  = inc_req & ~inc_ack_q;
    elig_usr  = usr_req & ~usr_ack_q;
    usr_aged  = elig_usr & (wait_cnt_q >= MAX_WAIT_C);

    grant_br  = elig_br;
    grant_usr = ~elig_br & (usr_aged | (elig_usr & ~elig_inc));
    grant_inc = ~elig_br & ~usr_aged & elig_inc;
    usr_blocked = grant_usr & PROT_EN &
                  ((usr_addr == ADDR_ZR) | (usr_addr == ADDR_PC));

    br_ack_d  = grant_br;
    // A redirect also retires a pending increment: its PC is stale.
    inc_ack_d = grant_inc | (grant_br & elig_inc);
    usr_ack_d = grant_usr;
    flush_d   = grant_br;
    wr_en_d   = grant_br | grant_inc | (grant_usr & ~usr_blocked);

    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (grant_br) begin
      wr_addr_d = ADDR_PC;
      wr_data_d = br_target;
    end else if (grant_inc) begin
      wr_addr_d = ADDR_PC;
      wr_data_d = inc_pc;
    end else if (grant_usr && !usr_blocked) begin
      wr_addr_d = usr_addr;
      wr_data_d = usr_data;
    end

    wait_cnt_d = wait_cnt_q;
    if (!usr_req || grant_usr) begin
      wait_cnt_d = '0;
    end else if (elig_usr && !(&wait_cnt_q)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    prot_err_d = prot_err_q;
    if (usr_blocked) begin
      prot_err_d = 1'b1;
    end else if (err_clr) begin
      prot_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_ack_q   <= 1'b0;
      inc_ack_q  <= 1'b0;
      usr_ack_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      flush_q    <= 1'b0;
      prot_err_q <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      br_ack_q   <= br_ack_d;
      inc_ack_q  <= inc_ack_d;
      usr_ack_q  <= usr_ack_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      flush_q    <= flush_d;
      prot_err_q <= prot_err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign br_ack   = br_ack_q;
  assign inc_ack  = inc_ack_q;
  assign usr_ack  = usr_ack_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign flush    = flush_q;
  assign prot_err = prot_err_q;

endmodule
`default_nettype wire

// File: doc/spc_reg_write_arbiter.md
Name: spc_reg_write_arbiter

Overview:
- Single-write-port arbiter and sequencer in front of the special register file (ZR, R1-R3, SP, LR, PC, CPSR).
- Shares one registered write channel between three requesters:
  - branch unit: PC redirect
  - fetch: PC increment
  - user/MOV path: any special reg by 3-bit address
- Enforces fixed priority with starvation aging for the user path, write protection of ZR/PC from the user path, and a flush pulse on branch redirect.

Parameters:
- MAX_WAIT, 4: consecutive lost cycles after which a pending usr request outranks inc.
- WAIT_W, 3: width of the usr wait counter; must hold MAX_WAIT.
- PROT_EN, 1: 1 = user writes to addr 0 (ZR) or 6 (PC) are blocked.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- br_req  in  1  branch write request
- br_target  in  32  new PC value
- br_ack  out  1  one-cycle grant pulse to branch unit
- inc_req  in  1  fetch PC-increment request
- inc_pc  in  32  incremented PC value
- inc_ack  out  1  one-cycle grant/discard pulse to fetch
- usr_req  in  1  user special-reg write request
- usr_addr  in  3  target register index 0-7
- usr_data  in  32  write data
- usr_ack  out  1  one-cycle grant pulse to user path
- err_clr  in  1  clears prot_err
- wr_en  out  1  register-file write strobe
- wr_addr  out  3  register-file write index
- wr_data  out  32  register-file write data
- flush  out  1  pipeline flush, aligned with branch write
- prot_err  out  1  sticky protection violation flag

Behaviour:
- Reset (reset=0, async): all outputs 0; wait counter 0. Takes effect immediately, including mid-grant; any in-flight ack or write is dropped.
- All outputs are registered. A request sampled at edge N produces ack and the write at edge N+1, so ack and wr_en are high during cycle N+1. Latency is 1 cycle.
- Handshake:
  - Requester holds req and payload stable until it samples its ack.
  - A requester whose ack is high in the current cycle is ineligible that cycle, so each requester gets at most one grant per 2 cycles.
  - Req still high after ack is a new request.
- Eligibility is req=1 and own ack=0.
- Priority, one winner per cycle:
  1. br
  2. usr if wait_cnt >= MAX_WAIT
  3. inc
  4. usr
- br grant: wr_en=1, wr_addr=6, wr_data=br_target, flush=1, br_ack=1. If inc is also eligible the same cycle, inc_ack=1 as well. Its inc_pc is discarded (stale after redirect) and no inc write occurs.
- inc grant: wr_en=1, wr_addr=6, wr_data=inc_pc, inc_ack=1.
- usr grant:
  - usr_ack=1.
  - If PROT_EN and usr_addr is 0 or 6: wr_en=0 and prot_err set.
  - Otherwise: wr_en=1, wr_addr=usr_addr, wr_data=usr_data.
- Wait counter:
  - Increments, saturating at all-ones, each edge where usr is eligible and not granted.
  - Cleared on usr grant or when usr_req=0.
- prot_err:
  - Set on a blocked usr write; cleared by err_clr.
  - Simultaneous set and clear: set wins.
- No eligible requester: wr_en, flush and all acks are 0. wr_addr/wr_data hold their last values (don't-care).
- Only one wr_en per cycle, ever. No combinational path from req to outputs.

Test Plan:
- Reset release, no requests -> all outputs 0 for 10 cycles. Assert reset mid-usr-grant -> usr_ack and wr_en drop to 0 immediately.
- inc_req=1, inc_pc=0x00000004 -> next cycle wr_en=1, wr_addr=6, wr_data=0x4, inc_ack=1. inc_req held continuously -> grants every other cycle.
- br_req=1 (br_target=0x00000100) and inc_req=1 in the same cycle -> wr_data=0x100, wr_addr=6, flush=1, br_ack=1, inc_ack=1, single wr_en.
- usr_req=1 (addr 4, data 0xDEAD0000) and inc_req=1 every cycle, MAX_WAIT=4 -> usr granted on or before its 5th cycle pending. wr_addr=4, wr_data=0xDEAD0000; wait counter returns to 0.
- usr_req=1 with addr 6, then addr 0 -> usr_ack=1, wr_en=0, prot_err=1. prot_err stays 1 until err_clr. err_clr on the same cycle as a new violation -> prot_err remains 1.
- PROT_EN=0, usr write to addr 6 with data 0x20 -> wr_en=1, wr_addr=6, wr_data=0x20, prot_err stays 0.
